// File: rtl/mu0_pkg.sv
// Shared opcode numbering, controller state encoding and the decoded-opcode bundle
// used by the MU0 control unit and its opcode decoder.
package mu0_pkg;

  localparam int OP_LDA = 0;
  localparam int OP_STA = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_JMP = 4;
  localparam int OP_JMI = 5;
  localparam int OP_JEQ = 6;
  localparam int OP_STP = 7;
  localparam int OP_LDI = 8;
  localparam int OP_LSR = 10;
  localparam int OP_ASR = 11;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC1 = 3'd1,
    ST_EXEC2 = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic lda;
    logic sta;
    logic add;
    logic sub;
    logic jmp;
    logic jmi;
    logic jeq;
    logic stp;
    logic ldi;
    logic lsr;
    logic asr;
    logic nop;
  } op_dec_t;

endpackage

// File: rtl/mu0_opdecode.sv
// One-hot decode of the MU0 opcode field; unassigned opcodes decode as NOP.
module mu0_opdecode
  import mu0_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output op_dec_t          dec
);

  always_comb begin
    dec = '0;
    case (opc)
      OPC_W'(OP_LDA): dec.lda = 1'b1;
      OPC_W'(OP_STA): dec.sta = 1'b1;
      OPC_W'(OP_ADD): dec.add = 1'b1;
      OPC_W'(OP_SUB): dec.sub = 1'b1;
      OPC_W'(OP_JMP): dec.jmp = 1'b1;
      OPC_W'(OP_JMI): dec.jmi = 1'b1;
      OPC_W'(OP_JEQ): dec.jeq = 1'b1;
      OPC_W'(OP_STP): dec.stp = 1'b1;
      OPC_W'(OP_LDI): dec.ldi = 1'b1;
      OPC_W'(OP_LSR): dec.lsr = 1'b1;
      OPC_W'(OP_ASR): dec.asr = 1'b1;
      default:        dec.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control FSM: sequences fetch, execute, multi-cycle shifts and halt,
// producing the datapath strobes combinationally from state, IR and status inputs.
//
// state | meaning
// FETCH | wait for instruction read, load IR on MEM_READY
// EXEC1 | first execute cycle; completes most instructions, first shift
// EXEC2 | operand read for LDA/ADD/SUB, waits on MEM_READY
// SHIFT | remaining shift cycles, counter holds shifts still to do
// HALT  | stopped until reset
module mu0_control
  import mu0_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 4,
  parameter int SHAMT_W = 4
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IR,
  input  logic              EQ,
  input  logic              MI,
  input  logic              SKIP,
  input  logic              MEM_READY,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              SHIFT,
  output logic              HALTED,
  output logic              IR_LOAD,
  output logic              Wren,
  output logic              MUX1,
  output logic              MUX3,
  output logic              EXTRA,
  output logic              PC_sload,
  output logic              PC_cnt_en,
  output logic              ACC_EN,
  output logic              ACC_LOAD,
  output logic              ACC_SHIFTIN,
  output logic              ADDSUB,
  output logic              MUX3_useAllBits
);

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  op_dec_t              op;
  logic [SHAMT_W-1:0]   shamt;
  logic [SHAMT_W-1:0]   shamt_m1;
  logic                 shift_last;
  logic                 jump_go;
  logic                 unused_ir;

  mu0_opdecode #(.OPC_W(OPC_W)) u_opdecode (
    .opc (IR[DATA_W-1 -: OPC_W]),
    .dec (op)
  );

  assign shamt      = IR[SHAMT_W-1:0];
  // A zero shift count still performs one shift.
  assign shamt_m1   = (shamt == '0) ? '0 : shamt - SHAMT_W'(1);
  assign shift_last = (shamt_m1 == '0);
  assign jump_go    = (op.jmp | (op.jmi & MI) | (op.jeq & EQ)) & ~SKIP;
  assign unused_ir  = ^IR[DATA_W-OPC_W-1:SHAMT_W];

  assign FETCH  = (state_q == ST_FETCH);
  assign EXEC1  = (state_q == ST_EXEC1);
  assign EXEC2  = (state_q == ST_EXEC2);
  assign SHIFT  = (state_q == ST_SHIFT);
  assign HALTED = (state_q == ST_HALT);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    IR_LOAD         = 1'b0;
    Wren            = 1'b0;
    MUX1            = 1'b0;
    MUX3            = 1'b0;
    EXTRA           = 1'b0;
    PC_sload        = 1'b0;
    PC_cnt_en       = 1'b0;
    ACC_EN          = 1'b0;
    ACC_LOAD        = 1'b0;
    ACC_SHIFTIN     = 1'b0;
    ADDSUB          = 1'b0;
    MUX3_useAllBits = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // Reset holds the state in FETCH, so gating here keeps every strobe low in reset.
        if (MEM_READY) begin
          IR_LOAD = RESET_N;
          state_d = ST_EXEC1;
        end
      end

      ST_EXEC1: begin
        if (op.lda | op.add | op.sub) begin
          MUX1    = 1'b1;
          EXTRA   = 1'b1;
          state_d = ST_EXEC2;
        end else if (op.sta) begin
          MUX1 = 1'b1;
          Wren = ~SKIP;
          if (MEM_READY) begin
            PC_cnt_en = 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (op.jmp | op.jmi | op.jeq) begin
          PC_sload  = jump_go;
          PC_cnt_en = ~jump_go;
          state_d   = ST_FETCH;
        end else if (op.stp) begin
          if (SKIP) begin
            PC_cnt_en = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_HALT;
          end
        end else if (op.ldi) begin
          MUX3      = 1'b1;
          ACC_EN    = ~SKIP;
          ACC_LOAD  = ~SKIP;
          PC_cnt_en = 1'b1;
          state_d   = ST_FETCH;
        end else if (op.lsr | op.asr) begin
          if (SKIP) begin
            PC_cnt_en = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            ACC_EN          = 1'b1;
            MUX3_useAllBits = 1'b1;
            ACC_SHIFTIN     = op.asr & MI;
            cnt_d           = shamt_m1;
            if (shift_last) begin
              PC_cnt_en = 1'b1;
              state_d   = ST_FETCH;
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end else begin
          PC_cnt_en = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_EXEC2: begin
        // Operand address stays selected until the read completes.
        MUX1 = 1'b1;
        if (MEM_READY) begin
          PC_cnt_en       = 1'b1;
          ACC_EN          = ~SKIP;
          ACC_LOAD        = ~SKIP;
          ADDSUB          = op.add & ~SKIP;
          MUX3            = op.lda;
          MUX3_useAllBits = op.lda;
          state_d         = ST_FETCH;
        end
      end

      ST_SHIFT: begin
        ACC_EN          = 1'b1;
        MUX3_useAllBits = 1'b1;
        ACC_SHIFTIN     = op.asr & MI;
        cnt_d           = cnt_q - SHAMT_W'(1);
        if (cnt_q <= SHAMT_W'(1)) begin
          PC_cnt_en = 1'b1;
          cnt_d     = '0;
          state_d   = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mu0_control.sv
// Directed and randomized checks of mu0_control against a per-instruction cycle
// model that expands each instruction into its expected sequence of output vectors.
module tb_mu0_control;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] IR = '0;
  logic        EQ = 1'b0, MI = 1'b0, SKIP = 1'b0, MEM_READY = 1'b0;
  logic        FETCH, EXEC1, EXEC2, SHIFT, HALTED, IR_LOAD, Wren, MUX1, MUX3, EXTRA;
  logic        PC_sload, PC_cnt_en, ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB, MUX3_useAllBits;

  mu0_control #(.DATA_W(16), .OPC_W(4), .SHAMT_W(4)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .IR(IR), .EQ(EQ), .MI(MI), .SKIP(SKIP),
    .MEM_READY(MEM_READY), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .SHIFT(SHIFT),
    .HALTED(HALTED), .IR_LOAD(IR_LOAD), .Wren(Wren), .MUX1(MUX1), .MUX3(MUX3),
    .EXTRA(EXTRA), .PC_sload(PC_sload), .PC_cnt_en(PC_cnt_en), .ACC_EN(ACC_EN),
    .ACC_LOAD(ACC_LOAD), .ACC_SHIFTIN(ACC_SHIFTIN), .ADDSUB(ADDSUB),
    .MUX3_useAllBits(MUX3_useAllBits)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic fetch, exec1, exec2, shift, halted, ir_load, wren, mux1, mux3, extra;
    logic pc_sload, pc_cnt_en, acc_en, acc_load, acc_shiftin, addsub, mux3_all;
  } outs_t;

  typedef struct {
    logic  rdy;
    outs_t exp;
    outs_t mask;
    string tag;
  } cyc_t;

  cyc_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  outs_t FULL;
  outs_t EX2M;

  function automatic outs_t ph(int p);
    outs_t o = '0;
    case (p)
      0: o.fetch = 1'b1;
      1: o.exec1 = 1'b1;
      2: o.exec2 = 1'b1;
      3: o.shift = 1'b1;
      default: o.halted = 1'b1;
    endcase
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o = '{FETCH, EXEC1, EXEC2, SHIFT, HALTED, IR_LOAD, Wren, MUX1, MUX3, EXTRA,
          PC_sload, PC_cnt_en, ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB, MUX3_useAllBits};
    return o;
  endfunction

  task automatic check(input outs_t e, input outs_t m, input string tag);
    outs_t obs;
    obs = sample();
    n_tests++;
    assert ((obs & m) === (e & m))
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs & m, e & m);
    end
  endtask

  task automatic push(input logic rdy, input outs_t e, input outs_t m, input string tag);
    cyc_t c;
    c.rdy = rdy; c.exp = e; c.mask = m; c.tag = tag;
    q.push_back(c);
  endtask

  // Expand one instruction into its cycle-by-cycle expected outputs.
  task automatic plan(input int opc, input int n, input logic eq, input logic mi,
                      input logic skip, input int fw, input int ew, input string tag);
    outs_t e;
    int    neff;
    logic  taken, go;
    for (int i = 0; i < fw; i++) push(1'b0, ph(0), FULL, {tag, "_fetchwait"});
    e = ph(0); e.ir_load = 1'b1;
    push(1'b1, e, FULL, {tag, "_fetch"});
    case (opc)
      0, 2, 3: begin
        e = ph(1); e.mux1 = 1'b1; e.extra = 1'b1;
        push(1'($urandom), e, FULL, {tag, "_ex1"});
        for (int i = 0; i < ew; i++) push(1'b0, ph(2), EX2M, {tag, "_ex2wait"});
        e = ph(2); e.pc_cnt_en = 1'b1;
        e.acc_en = !skip; e.acc_load = !skip;
        e.addsub = (opc == 2) && !skip;
        e.mux3 = (opc == 0); e.mux3_all = (opc == 0);
        push(1'b1, e, EX2M, {tag, "_ex2done"});
      end
      1: begin
        e = ph(1); e.mux1 = 1'b1; e.wren = !skip;
        for (int i = 0; i < ew; i++) push(1'b0, e, FULL, {tag, "_stawait"});
        e.pc_cnt_en = 1'b1;
        push(1'b1, e, FULL, {tag, "_stadone"});
      end
      4, 5, 6: begin
        taken = (opc == 4) ? 1'b1 : ((opc == 5) ? mi : eq);
        go = taken && !skip;
        e = ph(1); e.pc_sload = go; e.pc_cnt_en = !go;
        push(1'($urandom), e, FULL, {tag, "_jump"});
      end
      7: begin
        e = ph(1); e.pc_cnt_en = skip;
        push(1'($urandom), e, FULL, {tag, "_stp"});
      end
      8: begin
        e = ph(1); e.mux3 = 1'b1; e.acc_en = !skip; e.acc_load = !skip; e.pc_cnt_en = 1'b1;
        push(1'($urandom), e, FULL, {tag, "_ldi"});
      end
      10, 11: begin
        if (skip) begin
          e = ph(1); e.pc_cnt_en = 1'b1;
          push(1'($urandom), e, FULL, {tag, "_shskip"});
        end else begin
          neff = (n == 0) ? 1 : n;
          for (int k = 0; k < neff; k++) begin
            e = ph((k == 0) ? 1 : 3);
            e.acc_en = 1'b1; e.mux3_all = 1'b1;
            e.acc_shiftin = (opc == 11) && mi;
            e.pc_cnt_en = (k == neff - 1);
            push(1'($urandom), e, FULL, {tag, "_shift"});
          end
        end
      end
      default: begin
        e = ph(1); e.pc_cnt_en = 1'b1;
        push(1'($urandom), e, FULL, {tag, "_nop"});
      end
    endcase
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      MEM_READY = c.rdy;
      @(negedge CLOCK);
      check(c.exp, c.mask, c.tag);
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic set_in(input int opc, input int n, input logic eq, input logic mi,
                        input logic skip);
    IR = 16'($urandom);
    IR[15:12] = 4'(opc);
    IR[3:0] = 4'(n);
    EQ = eq; MI = mi; SKIP = skip;
  endtask

  task automatic do_instr(input int opc, input int n, input logic eq, input logic mi,
                          input logic skip, input int fw, input int ew, input string tag);
    set_in(opc, n, eq, mi, skip);
    plan(opc, n, eq, mi, skip, fw, ew, tag);
    run_q();
  endtask

  // Assert reset now (mid-cycle), confirm immediate return to FETCH with no strobes.
  task automatic abort_now(input string tag);
    MEM_READY = 1'b1;
    RESET_N = 1'b0;
    #1;
    check(ph(0), FULL, {tag, "_rst_now"});
    repeat (2) begin
      @(negedge CLOCK);
      check(ph(0), FULL, {tag, "_rst_hold"});
    end
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    int    opc, n, fw, ew;
    logic  skip;
    outs_t e;

    FULL = '1;
    EX2M = '1; EX2M.mux1 = 1'b0; EX2M.extra = 1'b0;

    RESET_N = 1'b0; MEM_READY = 1'b1;
    set_in(10, 3, 1'b1, 1'b1, 1'b0);
    @(negedge CLOCK);
    check(ph(0), FULL, "reset_state");
    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    check(ph(0), FULL, "reset_state2");
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;

    do_instr(0, 5, 1'b0, 1'b0, 1'b0, 1, 2, "lda_wait2");
    do_instr(11, 5, 1'b0, 1'b1, 1'b0, 0, 0, "asr_n5_mi");
    do_instr(10, 0, 1'b1, 1'b1, 1'b0, 0, 0, "lsr_n0");
    do_instr(6, 2, 1'b1, 1'b0, 1'b1, 0, 0, "jeq_skip");
    do_instr(6, 2, 1'b1, 1'b0, 1'b0, 0, 0, "jeq_taken");
    do_instr(2, 1, 1'b0, 1'b0, 1'b0, 0, 0, "add");
    do_instr(3, 1, 1'b0, 1'b0, 1'b1, 0, 1, "sub_skip");
    do_instr(1, 1, 1'b0, 1'b0, 1'b0, 2, 2, "sta");
    do_instr(1, 1, 1'b0, 1'b0, 1'b1, 0, 1, "sta_skip");
    do_instr(11, 9, 1'b0, 1'b1, 1'b1, 0, 0, "asr_skip");
    do_instr(8, 0, 1'b0, 1'b0, 1'b0, 0, 0, "ldi");
    do_instr(7, 0, 1'b0, 1'b0, 1'b1, 0, 0, "stp_skip");
    do_instr(15, 7, 1'b0, 1'b0, 1'b0, 0, 0, "nop_f");

    for (int i = 0; i < 50; i++) begin
      opc  = $urandom_range(0, 15);
      n    = $urandom_range(0, 15);
      fw   = $urandom_range(0, 2);
      ew   = $urandom_range(0, 2);
      skip = ($urandom_range(0, 3) == 0);
      if (opc == 7) skip = 1'b1;
      do_instr(opc, n, 1'($urandom), 1'($urandom), skip, fw, ew, "rand");
    end

    set_in(7, 0, 1'b0, 1'b0, 1'b0);
    plan(7, 0, 1'b0, 1'b0, 1'b0, 0, 0, "stp_halt");
    for (int i = 0; i < 20; i++) push(1'(i), ph(4), FULL, "halted_hold");
    run_q();
    abort_now("halt");
    do_instr(13, 0, 1'b0, 1'b0, 1'b0, 0, 0, "after_halt");

    set_in(10, 8, 1'b0, 1'b1, 1'b0);
    plan(10, 8, 1'b0, 1'b1, 1'b0, 0, 0, "lsr8");
    while (q.size() > 3) q.delete(q.size() - 1);
    run_q();
    @(negedge CLOCK);
    e = ph(3); e.acc_en = 1'b1; e.mux3_all = 1'b1;
    check(e, FULL, "lsr8_shift3");
    #2;
    abort_now("lsr8");
    do_instr(12, 0, 1'b0, 1'b0, 1'b0, 0, 0, "after_shift_rst");

    set_in(0, 0, 1'b0, 1'b0, 1'b0);
    plan(0, 0, 1'b0, 1'b0, 1'b0, 0, 3, "lda_rst");
    while (q.size() > 3) q.delete(q.size() - 1);
    run_q();
    #3;
    abort_now("exec2");
    do_instr(2, 0, 1'b0, 1'b0, 1'b0, 0, 1, "after_exec2_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set instruction/data width (minimum 12).
REQ-002 Parameter OPC_W, default 4, SHALL set opcode field width at IR[DATA_W-1 -: OPC_W].
REQ-003 Parameter SHAMT_W, default 4, SHALL set shift-count field width at IR[SHAMT_W-1:0].
REQ-004 Ports SHALL be:
- CLOCK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IR  in  DATA_W  current instruction register contents.
- EQ, MI  in  1 each  accumulator zero and negative flags.
- SKIP  in  1  skip status; when high, the current instruction is architecturally suppressed.
- MEM_READY  in  1  memory access completes this cycle.
- FETCH, EXEC1, EXEC2, SHIFT  out  1 each  one-hot phase indicators.
- HALTED  out  1  processor stopped.
- IR_LOAD  out  1  load IR from memory.
- Wren, MUX1, MUX3, EXTRA  out  1 each  memory write, address select, ACC-input select, extra-cycle flag.
- PC_sload, PC_cnt_en  out  1 each  PC load / increment.
- ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB, MUX3_useAllBits  out  1 each  accumulator controls.

Function
REQ-005 Opcodes SHALL be: LDA 0, STA 1, ADD 2, SUB 3, JMP 4, JMI 5, JEQ 6, STP 7, LDI 8, LSR A, ASR B; all others execute as NOP (PC_cnt_en in EXEC1 only).
REQ-006 State machine SHALL have states FETCH, EXEC1, EXEC2, SHIFT, HALT; exactly one phase output is high, or HALTED alone.
REQ-007 FETCH SHALL hold until MEM_READY=1; in that cycle IR_LOAD=1, next state EXEC1.
REQ-008 EXEC1 with LDA/ADD/SUB: MUX1=1, EXTRA=1, next EXEC2; STA: MUX1=1, Wren=!SKIP, held in EXEC1 until MEM_READY, then PC_cnt_en=1, next FETCH.
REQ-009 EXEC2 SHALL hold until MEM_READY; in the completing cycle PC_cnt_en=1, ACC_EN=ACC_LOAD=!SKIP, ADDSUB=ADD&!SKIP, MUX3=MUX3_useAllBits=LDA; next FETCH.
REQ-010 JMP/JMI/JEQ in EXEC1: PC_sload=taken&!SKIP, PC_cnt_en otherwise; taken = 1, MI, EQ respectively; next FETCH.
REQ-011 LDI in EXEC1: MUX3=1, ACC_EN=ACC_LOAD=!SKIP, PC_cnt_en=1, next FETCH.
REQ-012 LSR/ASR: shift count N=IR[SHAMT_W-1:0], N=0 treated as 1; one shift per cycle with ACC_EN=1, ACC_LOAD=0, MUX3_useAllBits=1, ACC_SHIFTIN=ASR&MI.
REQ-013 Shift: EXEC1 performs shift 1 and loads a SHAMT_W-bit counter with N-1; if N<=1, PC_cnt_en=1 and next FETCH, else next SHIFT.
REQ-014 SHIFT SHALL shift and decrement each cycle; on the cycle counter==1, PC_cnt_en=1 and next FETCH; total shift cycles exactly N.
REQ-015 SKIP high in EXEC1 of LSR/ASR SHALL suppress all shifts, assert PC_cnt_en, and go to FETCH.
REQ-016 STP in EXEC1: SKIP=1 -> PC_cnt_en=1, next FETCH; else next HALT; HALT is absorbing until reset with all strobes low.
REQ-017 All outputs SHALL be combinational from state, IR, flags, SKIP, MEM_READY; only state and shift counter are registered.
REQ-018 IR changes outside FETCH are illegal and SHALL NOT be relied upon.

Reset
REQ-019 RESET_N low SHALL asynchronously force state FETCH and counter 0; all strobes except FETCH SHALL be low during reset.
REQ-020 Reset asserted mid-EXEC2, mid-SHIFT or in HALT SHALL abandon the operation with no further ACC_EN/PC pulses.
REQ-021 Reset release SHALL be synchronised externally; first active edge after release evaluates FETCH.

Structure
REQ-022 Opcode constants and the state encoding SHALL live in shared package mu0_pkg.
REQ-023 One sub-module, mu0_opdecode (combinational opcode one-hot decode), SHALL be instantiated.

Verification
REQ-024 LDA with MEM_READY low 2 cycles in EXEC2 -> EXEC2 held 3 cycles; ACC_EN, ACC_LOAD, PC_cnt_en pulse once in the third.
REQ-025 ASR, N=5, MI=1 -> EXEC1 plus 4 SHIFT cycles, ACC_EN high 5 cycles, ACC_SHIFTIN=1 throughout, PC_cnt_en only in the last.
REQ-026 LSR, N=0 -> one shift in EXEC1, PC_cnt_en same cycle, next FETCH.
REQ-027 JEQ with EQ=1, SKIP=1 -> PC_sload=0, PC_cnt_en=1; with SKIP=0 -> PC_sload=1, PC_cnt_en=0.
REQ-028 STP, SKIP=0 -> HALTED stays high for 20 cycles despite MEM_READY toggling; RESET_N pulse -> FETCH.
REQ-029 RESET_N asserted at SHIFT count 3 of 8 -> immediate FETCH, no further ACC_EN.
